// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register index width, hazard FSM encodings,
// forwarding-select codes and the "non-$0 register match" helper.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] reg_idx_t;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_STALL = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // $0 is hardwired to zero, so it never matches as a producer.
  function automatic logic reg_match(input reg_idx_t producer, input reg_idx_t consumer);
    return (producer != '0) && (producer == consumer);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// Operand forwarding select for one ALU input.
// EX/MEM (the younger result) wins over MEM/WB.
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_reg_i,
  input  logic             exmem_regwrite_i,
  input  logic [REG_W-1:0] exmem_wreg_i,
  input  logic             memwb_regwrite_i,
  input  logic [REG_W-1:0] memwb_wreg_i,
  output logic [1:0]       fwd_sel_o
);

  always_comb begin
    if (exmem_regwrite_i && reg_match(exmem_wreg_i, src_reg_i)) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (memwb_regwrite_i && reg_match(memwb_wreg_i, src_reg_i)) begin
      fwd_sel_o = FWD_MEMWB;
    end else begin
      fwd_sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall FSM, branch flush,
// operand forwarding and saturating stall/flush event counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LU_CYCLES = 1   // bubbles per load-use hazard, 1..7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic [REG_W-1:0] idex_rs,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_wreg,
  input  logic             exmem_regwrite,
  input  logic [REG_W-1:0] exmem_wreg,
  input  logic             memwb_regwrite,
  input  logic [REG_W-1:0] memwb_wreg,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // The RUN cycle that detects the hazard is the first bubble, so the
  // down-counter only covers the remaining ones.
  localparam logic [2:0] LU_RELOAD = 3'(LU_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_evt;
  logic             flush_evt;

  assign lu = idex_memread && (reg_match(idex_wreg, ifid_rs) || reg_match(idex_wreg, ifid_rt));

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      lu_cnt_d    = '0;
      state_d     = ST_FLUSH;
      flush_evt   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
            if (LU_CYCLES > 1) begin
              state_d  = ST_STALL;
              lu_cnt_d = LU_RELOAD;
            end
          end
        end
        ST_STALL: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          if (lu_cnt_q <= 3'd1) begin
            state_d  = ST_RUN;
            lu_cnt_d = '0;
          end else begin
            lu_cnt_d = lu_cnt_q - 3'd1;
          end
        end
        ST_FLUSH: state_d = ST_RUN;
        default: begin
          state_d  = ST_RUN;
          lu_cnt_d = '0;
        end
      endcase
    end

    // Reset cycle drives a clean pipeline regardless of the current state.
    if (rst) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      lu_cnt_q    <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  forward_unit u_fwd_a (
    .src_reg_i        (idex_rs),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_wreg_i     (exmem_wreg),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_wreg_i     (memwb_wreg),
    .fwd_sel_o        (fwd_a)
  );

  forward_unit u_fwd_b (
    .src_reg_i        (idex_rt),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_wreg_i     (exmem_wreg),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_wreg_i     (memwb_wreg),
    .fwd_sel_o        (fwd_b)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: three instances share stimulus
// (LU_CYCLES=1/CNT_W=4, LU_CYCLES=3, LU_CYCLES=4) and are checked per scenario.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_wreg, exmem_wreg, memwb_wreg;
  logic       idex_memread, exmem_regwrite, memwb_regwrite, branch_taken;

  // Index 0: LU_CYCLES=1 CNT_W=4, 1: LU_CYCLES=3, 2: LU_CYCLES=4
  logic       pc_write[3], ifid_write[3], idex_bubble[3];
  logic       ifid_flush[3], idex_flush[3], exmem_flush[3];
  logic [1:0] fwd_a[3], fwd_b[3], state[3];
  logic [3:0]  scnt1, fcnt1;
  logic [15:0] scnt3, fcnt3, scnt4, fcnt4;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(4), .LU_CYCLES(1)) u_dut1 (
    .clk, .rst, .ifid_rs, .ifid_rt, .idex_rs, .idex_rt, .idex_memread, .idex_wreg,
    .exmem_regwrite, .exmem_wreg, .memwb_regwrite, .memwb_wreg, .branch_taken,
    .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .idex_bubble(idex_bubble[0]),
    .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]),
    .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .state(state[0]),
    .stall_cnt(scnt1), .flush_cnt(fcnt1)
  );

  pipeline_hazard_ctrl #(.CNT_W(16), .LU_CYCLES(3)) u_dut3 (
    .clk, .rst, .ifid_rs, .ifid_rt, .idex_rs, .idex_rt, .idex_memread, .idex_wreg,
    .exmem_regwrite, .exmem_wreg, .memwb_regwrite, .memwb_wreg, .branch_taken,
    .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .idex_bubble(idex_bubble[1]),
    .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]),
    .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .state(state[1]),
    .stall_cnt(scnt3), .flush_cnt(fcnt3)
  );

  pipeline_hazard_ctrl #(.CNT_W(16), .LU_CYCLES(4)) u_dut4 (
    .clk, .rst, .ifid_rs, .ifid_rt, .idex_rs, .idex_rt, .idex_memread, .idex_wreg,
    .exmem_regwrite, .exmem_wreg, .memwb_regwrite, .memwb_wreg, .branch_taken,
    .pc_write(pc_write[2]), .ifid_write(ifid_write[2]), .idex_bubble(idex_bubble[2]),
    .ifid_flush(ifid_flush[2]), .idex_flush(idex_flush[2]), .exmem_flush(exmem_flush[2]),
    .fwd_a(fwd_a[2]), .fwd_b(fwd_b[2]), .state(state[2]),
    .stall_cnt(scnt4), .flush_cnt(fcnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ifid_rs = '0; ifid_rt = '0; idex_rs = '0; idex_rt = '0;
    idex_memread = 1'b0; idex_wreg = '0;
    exmem_regwrite = 1'b0; exmem_wreg = '0;
    memwb_regwrite = 1'b0; memwb_wreg = '0;
    branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // lw $2 in ID/EX, consumer reads $2 in IF/ID
  task automatic apply_lu();
    idex_memread = 1'b1;
    idex_wreg    = 5'd2;
    ifid_rs      = 5'd2;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;

    // Reset cycle: hazard and branch present, outputs must stay clean
    apply_lu();
    branch_taken = 1'b1;
    settle();
    check("rst_pc_write",   32'(pc_write[0]),    32'd1);
    check("rst_ifid_write", 32'(ifid_write[0]),  32'd1);
    check("rst_bubble",     32'(idex_bubble[0]), 32'd0);
    check("rst_flushes",    32'({ifid_flush[0], idex_flush[0], exmem_flush[0]}), 32'd0);
    tick();
    check("rst_state", 32'(state[0]), 32'(ST_RUN));
    check("rst_fcnt",  32'(fcnt1),    32'd0);
    check("rst_scnt",  32'(scnt1),    32'd0);
    clear_inputs();
    rst = 1'b0;
    tick();

    // $0 as load destination never stalls
    idex_memread = 1'b1;
    settle();
    check("r0_bubble",   32'(idex_bubble[0]), 32'd0);
    check("r0_pc_write", 32'(pc_write[0]),    32'd1);
    // Hazard through the rt operand
    idex_wreg = 5'd3;
    ifid_rt   = 5'd3;
    settle();
    check("lu_rt_bubble", 32'(idex_bubble[0]), 32'd1);

    // Load-use, one cycle of stimulus
    ifid_rt = '0;
    apply_lu();
    settle();
    check("lu1_pc_write",   32'(pc_write[0]),    32'd0);
    check("lu1_ifid_write", 32'(ifid_write[0]),  32'd0);
    check("lu1_bubble",     32'(idex_bubble[0]), 32'd1);
    check("lu1_scnt_pre",   32'(scnt1),          32'd0);
    check("lu3_bubble_c0",  32'(idex_bubble[1]), 32'd1);
    check("lu4_bubble_c0",  32'(idex_bubble[2]), 32'd1);
    tick();
    clear_inputs();
    settle();
    check("lu1_scnt",     32'(scnt1),          32'd1);
    check("lu1_state",    32'(state[0]),       32'(ST_RUN));
    check("lu1_bubble_n", 32'(idex_bubble[0]), 32'd0);
    check("lu1_pc_n",     32'(pc_write[0]),    32'd1);
    check("lu3_state_c1", 32'(state[1]),       32'(ST_STALL));
    check("lu3_bubble_c1", 32'(idex_bubble[1]), 32'd1);
    check("lu4_state_c1", 32'(state[2]),       32'(ST_STALL));
    tick();
    check("lu3_state_c2",  32'(state[1]),       32'(ST_STALL));
    check("lu3_bubble_c2", 32'(idex_bubble[1]), 32'd1);
    tick();
    check("lu3_state_c3",  32'(state[1]),       32'(ST_RUN));
    check("lu3_bubble_c3", 32'(idex_bubble[1]), 32'd0);
    check("lu3_scnt",      32'(scnt3),          32'd1);
    check("lu4_bubble_c3", 32'(idex_bubble[2]), 32'd1);
    tick();
    check("lu4_state_c4",  32'(state[2]),       32'(ST_RUN));
    check("lu4_bubble_c4", 32'(idex_bubble[2]), 32'd0);
    check("lu4_scnt",      32'(scnt4),          32'd1);

    // Branch coincident with load-use: branch wins
    do_reset();
    apply_lu();
    branch_taken = 1'b1;
    settle();
    check("br_flushes",  32'({ifid_flush[0], idex_flush[0], exmem_flush[0]}), 32'b111);
    check("br_bubble",   32'(idex_bubble[0]), 32'd0);
    check("br_pc_write", 32'(pc_write[0]),    32'd1);
    check("br_ifid_wr",  32'(ifid_write[0]),  32'd1);
    tick();
    branch_taken = 1'b0;
    settle();
    check("br_state_flush", 32'(state[0]),       32'(ST_FLUSH));
    check("br_fl_bubble",   32'(idex_bubble[0]), 32'd0);
    check("br_fl_pc_write", 32'(pc_write[0]),    32'd1);
    check("br_fl_flushes",  32'({ifid_flush[0], idex_flush[0], exmem_flush[0]}), 32'd0);
    clear_inputs();
    tick();
    check("br_state_run", 32'(state[0]), 32'(ST_RUN));
    check("br_fcnt",      32'(fcnt1),    32'd1);
    check("br_scnt",      32'(scnt1),    32'd0);

    // Branch arriving in the middle of a STALL
    do_reset();
    apply_lu();
    tick();
    clear_inputs();
    settle();
    check("bs_state_stall", 32'(state[1]), 32'(ST_STALL));
    branch_taken = 1'b1;
    settle();
    check("bs_bubble",   32'(idex_bubble[1]), 32'd0);
    check("bs_pc_write", 32'(pc_write[1]),    32'd1);
    check("bs_exmem_fl", 32'(exmem_flush[1]), 32'd1);
    tick();
    branch_taken = 1'b0;
    settle();
    check("bs_state_flush", 32'(state[1]),       32'(ST_FLUSH));
    check("bs_fl_bubble",   32'(idex_bubble[1]), 32'd0);
    tick();
    check("bs_state_run", 32'(state[1]),       32'(ST_RUN));
    check("bs_run_bubble", 32'(idex_bubble[1]), 32'd0);
    check("bs_scnt",      32'(scnt3),          32'd1);
    check("bs_fcnt",      32'(fcnt3),          32'd1);

    // Forwarding priority and $0 suppression
    clear_inputs();
    exmem_regwrite = 1'b1; memwb_regwrite = 1'b1;
    exmem_wreg = 5'd5; memwb_wreg = 5'd5;
    idex_rs = 5'd5; idex_rt = 5'd5;
    settle();
    check("fwd_both_a", 32'(fwd_a[0]), 32'b10);
    check("fwd_both_b", 32'(fwd_b[0]), 32'b10);
    exmem_regwrite = 1'b0;
    settle();
    check("fwd_memwb_a", 32'(fwd_a[0]), 32'b01);
    check("fwd_memwb_b", 32'(fwd_b[0]), 32'b01);
    exmem_regwrite = 1'b1;
    exmem_wreg = '0; memwb_wreg = '0;
    idex_rs = '0; idex_rt = '0;
    settle();
    check("fwd_r0_a", 32'(fwd_a[0]), 32'b00);
    check("fwd_r0_b", 32'(fwd_b[0]), 32'b00);
    exmem_wreg = 5'd5; memwb_wreg = 5'd7;
    idex_rs = 5'd5; idex_rt = 5'd7;
    settle();
    check("fwd_mix_a", 32'(fwd_a[0]), 32'b10);
    check("fwd_mix_b", 32'(fwd_b[0]), 32'b01);

    // Reset at the second bubble of a 4-cycle stall
    do_reset();
    apply_lu();
    tick();
    clear_inputs();
    settle();
    check("rs_state_stall", 32'(state[2]), 32'(ST_STALL));
    rst = 1'b1;
    settle();
    check("rs_pc_write_rst", 32'(pc_write[2]),    32'd1);
    check("rs_bubble_rst",   32'(idex_bubble[2]), 32'd0);
    tick();
    rst = 1'b0;
    settle();
    check("rs_state",    32'(state[2]),       32'(ST_RUN));
    check("rs_pc_write", 32'(pc_write[2]),    32'd1);
    check("rs_bubble",   32'(idex_bubble[2]), 32'd0);
    check("rs_scnt",     32'(scnt4),          32'd0);
    check("rs_fcnt",     32'(fcnt4),          32'd0);
    tick();
    check("rs_bubble_next", 32'(idex_bubble[2]), 32'd0);

    // flush_cnt saturation with CNT_W=4
    do_reset();
    branch_taken = 1'b1;
    repeat (15) tick();
    check("sat_fcnt_15", 32'(fcnt1), 32'd15);
    tick();
    check("sat_fcnt_16", 32'(fcnt1), 32'd15);
    check("sat_state",   32'(state[0]), 32'(ST_FLUSH));
    clear_inputs();
    tick();
    check("sat_state_run", 32'(state[0]), 32'(ST_RUN));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
